// File: rtl/mpf_svc_vtp_l1_miss_handler.sv
// mpf_svc_vtp_l1_miss_handler
//
// Consumer end of a port's L1 TLB lookup response channel. L1 hits are
// forwarded straight to the translated-request output slot. L1 misses are
// sent one at a time, in order, to the shared VTP TLB service. The returned
// translation is written back into the L1 caches and delivered downstream
// together with the original request fields.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   l1_*                  head of the L1 lookup FIFO; l1_deq pops it
//   svc_req_*             miss request to the shared service (valid/ready)
//   svc_rsp_*             service response, single-cycle pulse, always taken
//   insertVA/insertPA,
//   en_insert_4kb/2mb     one-cycle L1 fill strobes
//   out_*                 translated result, single-entry valid/ready slot
//   miss_count            saturating count of misses issued
module mpf_svc_vtp_l1_miss_handler #(
  parameter int N_VA_PAGE_BITS = 36,
  parameter int N_PA_PAGE_BITS = 40,
  parameter int N_TAG_BITS     = 8,
  parameter int N_OPAQUE_BITS  = 16,
  parameter int DEBUG_MESSAGES = 0
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      l1_notEmpty,
  input  logic [N_VA_PAGE_BITS-1:0] l1_va,
  input  logic [N_TAG_BITS-1:0]     l1_tag,
  input  logic [N_OPAQUE_BITS-1:0]  l1_opaque,
  input  logic                      l1_error,
  input  logic                      l1_isBigPage,
  input  logic [N_PA_PAGE_BITS-1:0] l1_pa,
  output logic                      l1_deq,

  output logic                      svc_req_valid,
  output logic [N_VA_PAGE_BITS-1:0] svc_req_va,
  output logic [N_TAG_BITS-1:0]     svc_req_tag,
  input  logic                      svc_req_ready,

  input  logic                      svc_rsp_valid,
  input  logic [N_PA_PAGE_BITS-1:0] svc_rsp_pa,
  input  logic                      svc_rsp_isBigPage,
  input  logic                      svc_rsp_mayCache,
  input  logic                      svc_rsp_error,

  output logic [N_VA_PAGE_BITS-1:0] insertVA,
  output logic [N_PA_PAGE_BITS-1:0] insertPA,
  output logic                      en_insert_4kb,
  output logic                      en_insert_2mb,

  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_VA_PAGE_BITS-1:0] out_va,
  output logic [N_TAG_BITS-1:0]     out_tag,
  output logic [N_OPAQUE_BITS-1:0]  out_opaque,
  output logic [N_PA_PAGE_BITS-1:0] out_pa,
  output logic                      out_isBigPage,
  output logic                      out_mayCache,
  output logic                      out_error,

  output logic [31:0]               miss_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_FILL = 2'd3;

  // Miss tracing is a simulation-only aid; the synthesizable core accepts
  // the switch for interface compatibility but emits nothing.
  if (DEBUG_MESSAGES != 0) begin : gDebugHook
  end

  logic [1:0]                state_q, state_d;
  logic [N_VA_PAGE_BITS-1:0] missVa_q, missVa_d;
  logic [N_TAG_BITS-1:0]     missTag_q, missTag_d;
  logic [N_OPAQUE_BITS-1:0]  missOpaque_q, missOpaque_d;
  logic [N_PA_PAGE_BITS-1:0] rspPa_q, rspPa_d;
  logic                      rspBig_q, rspBig_d;
  logic                      rspMayCache_q, rspMayCache_d;
  logic                      rspErr_q, rspErr_d;
  logic                      outValid_q, outValid_d;
  logic [N_VA_PAGE_BITS-1:0] outVa_q, outVa_d;
  logic [N_TAG_BITS-1:0]     outTag_q, outTag_d;
  logic [N_OPAQUE_BITS-1:0]  outOpaque_q, outOpaque_d;
  logic [N_PA_PAGE_BITS-1:0] outPa_q, outPa_d;
  logic                      outBig_q, outBig_d;
  logic                      outMayCache_q, outMayCache_d;
  logic                      outErr_q, outErr_d;
  logic [31:0]               missCount_q, missCount_d;
  logic                      slotFree;
  logic                      doInsert;

  // The output slot can take a new entry when empty or when its current
  // entry is being consumed in this same cycle.
  assign slotFree = !outValid_q || out_ready;

  // Next-state logic. Misses are dequeued without needing a free slot; the
  // slot is only required when the result is finally written in FILL.
  // Nothing is dequeued outside IDLE, which keeps hits behind a miss in order.
  always_comb begin
    state_d       = state_q;
    missVa_d      = missVa_q;
    missTag_d     = missTag_q;
    missOpaque_d  = missOpaque_q;
    rspPa_d       = rspPa_q;
    rspBig_d      = rspBig_q;
    rspMayCache_d = rspMayCache_q;
    rspErr_d      = rspErr_q;
    outValid_d    = outValid_q && !out_ready;
    outVa_d       = outVa_q;
    outTag_d      = outTag_q;
    outOpaque_d   = outOpaque_q;
    outPa_d       = outPa_q;
    outBig_d      = outBig_q;
    outMayCache_d = outMayCache_q;
    outErr_d      = outErr_q;
    missCount_d   = missCount_q;
    l1_deq        = 1'b0;
    doInsert      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (l1_notEmpty) begin
          if (l1_error) begin
            l1_deq       = 1'b1;
            missVa_d     = l1_va;
            missTag_d    = l1_tag;
            missOpaque_d = l1_opaque;
            missCount_d  = (missCount_q == 32'hFFFF_FFFF) ? missCount_q
                                                          : missCount_q + 32'd1;
            state_d      = ST_REQ;
          end else if (slotFree) begin
            l1_deq        = 1'b1;
            outValid_d    = 1'b1;
            outVa_d       = l1_va;
            outTag_d      = l1_tag;
            outOpaque_d   = l1_opaque;
            outPa_d       = l1_pa;
            outBig_d      = l1_isBigPage;
            outMayCache_d = 1'b1;
            outErr_d      = 1'b0;
          end
        end
      end
      ST_REQ: begin
        if (svc_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (svc_rsp_valid) begin
          rspPa_d       = svc_rsp_pa;
          rspBig_d      = svc_rsp_isBigPage;
          rspMayCache_d = svc_rsp_mayCache;
          rspErr_d      = svc_rsp_error;
          state_d       = ST_FILL;
        end
      end
      ST_FILL: begin
        if (slotFree) begin
          outValid_d    = 1'b1;
          outVa_d       = missVa_q;
          outTag_d      = missTag_q;
          outOpaque_d   = missOpaque_q;
          outPa_d       = rspErr_q ? '0 : rspPa_q;
          outBig_d      = rspBig_q;
          outMayCache_d = rspMayCache_q;
          outErr_d      = rspErr_q;
          doInsert      = !rspErr_q && rspMayCache_q;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any miss in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      missVa_q      <= '0;
      missTag_q     <= '0;
      missOpaque_q  <= '0;
      rspPa_q       <= '0;
      rspBig_q      <= 1'b0;
      rspMayCache_q <= 1'b0;
      rspErr_q      <= 1'b0;
      outValid_q    <= 1'b0;
      outVa_q       <= '0;
      outTag_q      <= '0;
      outOpaque_q   <= '0;
      outPa_q       <= '0;
      outBig_q      <= 1'b0;
      outMayCache_q <= 1'b0;
      outErr_q      <= 1'b0;
      missCount_q   <= '0;
    end else begin
      state_q       <= state_d;
      missVa_q      <= missVa_d;
      missTag_q     <= missTag_d;
      missOpaque_q  <= missOpaque_d;
      rspPa_q       <= rspPa_d;
      rspBig_q      <= rspBig_d;
      rspMayCache_q <= rspMayCache_d;
      rspErr_q      <= rspErr_d;
      outValid_q    <= outValid_d;
      outVa_q       <= outVa_d;
      outTag_q      <= outTag_d;
      outOpaque_q   <= outOpaque_d;
      outPa_q       <= outPa_d;
      outBig_q      <= outBig_d;
      outMayCache_q <= outMayCache_d;
      outErr_q      <= outErr_d;
      missCount_q   <= missCount_d;
    end
  end

  assign svc_req_valid = (state_q == ST_REQ);
  assign svc_req_va    = missVa_q;
  assign svc_req_tag   = missTag_q;

  // Fill strobes fire in the cycle the miss result enters the output slot.
  assign insertVA      = doInsert ? missVa_q : '0;
  assign insertPA      = doInsert ? rspPa_q : '0;
  assign en_insert_2mb = doInsert && rspBig_q;
  assign en_insert_4kb = doInsert && !rspBig_q;

  assign out_valid     = outValid_q;
  assign out_va        = outVa_q;
  assign out_tag       = outTag_q;
  assign out_opaque    = outOpaque_q;
  assign out_pa        = outPa_q;
  assign out_isBigPage = outBig_q;
  assign out_mayCache  = outMayCache_q;
  assign out_error     = outErr_q;
  assign miss_count    = missCount_q;

endmodule
